// File: rtl/board_commit_scheduler_pkg.sv
// Shared constants, FSM encoding and entry legality check for the board commit scheduler.
package board_commit_scheduler_pkg;
  localparam int V_ACTIVE = 480;
  localparam int V_TOTAL  = 525;
  localparam int N_CELLS  = 81;
  localparam int CELL_W   = 4;
  localparam int IDX_W    = 7;
  localparam int ENTRY_W  = IDX_W + CELL_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    CLEAR   = 2'd2,
    COMMIT  = 2'd3
  } fsm_state_e;

  function automatic logic entry_legal(input logic [IDX_W-1:0] idx, input logic [CELL_W-1:0] val);
    return (idx < IDX_W'(N_CELLS)) && (val <= CELL_W'(9));
  endfunction
endpackage

// File: rtl/board_commit_scheduler_commit_fifo.sv
// Synchronous FIFO with full/empty flags; head entry is presented combinationally.
module board_commit_scheduler_commit_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/board_commit_scheduler.sv
// Display-board owner: round-robin write arbiter, commit FIFO, blanking-only commit FSM.
// Optional BOARD_LOCK_EN adds lock_mask: locked cells refuse writes and survive CLEAR.
module board_commit_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int V_ACTIVE    = board_commit_scheduler_pkg::V_ACTIVE,
  parameter int MAX_COMMITS = 8
) (
  input  logic         clka,
  input  logic         rst,
  input  logic [9:0]   v_cnt,
  input  logic         req0_valid,
  input  logic [6:0]   req0_idx,
  input  logic [3:0]   req0_val,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [6:0]   req1_idx,
  input  logic [3:0]   req1_val,
  output logic         req1_ready,
  input  logic         clear_req,
`ifdef BOARD_LOCK_EN
  input  logic [80:0]  lock_mask,
`endif
  output logic [323:0] board,
  output logic [80:0]  board_blank,
  output logic         busy,
  output logic         frame_tick,
  output logic [7:0]   drop_cnt,
  output logic [1:0]   dbg_state
);
  import board_commit_scheduler_pkg::*;

  localparam int CNT_W = $clog2(MAX_COMMITS + 1);

  fsm_state_e         state;
  logic               vblank, vblank_q, vb_entry, go;
  logic               last1, grant0, grant1;
  logic               full, empty, push, pop;
  logic [ENTRY_W-1:0] push_data, head;
  logic [IDX_W-1:0]   head_idx;
  logic [CELL_W-1:0]  head_val;
  logic               head_ok;
  logic               clear_pend, hold_frame, at_limit;
  logic [CNT_W-1:0]   commit_cnt;

  assign vblank   = (v_cnt >= 10'(V_ACTIVE));
  assign vb_entry = vblank & ~vblank_q;

  // Handshake: a request transfers on a cycle where valid & ready; ready never depends on
  // anything but grant and FIFO fullness, and a requester must hold its payload until taken.
  assign grant0     = req0_valid & (~req1_valid | last1);
  assign grant1     = req1_valid & (~req0_valid | ~last1);
  assign req0_ready = grant0 & ~full;
  assign req1_ready = grant1 & ~full;
  assign push       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign push_data  = req0_ready ? {req0_idx, req0_val} : {req1_idx, req1_val};

  board_commit_scheduler_commit_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clka),
    .rst     (rst),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  assign {head_idx, head_val} = head;
`ifdef BOARD_LOCK_EN
  assign head_ok = entry_legal(head_idx, head_val) & ~lock_mask[head_idx];
`else
  assign head_ok = entry_legal(head_idx, head_val);
`endif

  // hold_frame keeps a stopped frame from restarting before the next blanking entry.
  assign at_limit  = (commit_cnt >= CNT_W'(MAX_COMMITS));
  assign go        = vblank & (~hold_frame | vb_entry);
  assign pop       = (state == COMMIT) & vblank & ~at_limit & ~clear_pend & ~empty;
  assign busy      = ~empty | clear_pend;
  assign dbg_state = state;

  always_ff @(posedge clka) begin
    if (rst) begin
      state       <= IDLE;
      vblank_q    <= 1'b0;
      frame_tick  <= 1'b0;
      last1       <= 1'b1;
      clear_pend  <= 1'b0;
      hold_frame  <= 1'b0;
      commit_cnt  <= '0;
      drop_cnt    <= '0;
      board       <= '0;
      board_blank <= '1;
    end else begin
      vblank_q   <= vblank;
      frame_tick <= vb_entry;
      if (push) last1 <= req1_ready;

      if (vb_entry) begin
        commit_cnt <= '0;
        hold_frame <= 1'b0;
      end else if (pop) begin
        commit_cnt <= commit_cnt + 1'b1;
      end

      if (clear_req) clear_pend <= 1'b1;
      else if (state == CLEAR) clear_pend <= 1'b0;

      if (pop) begin
        if (head_ok) begin
          board[{head_idx, 2'b00} +: CELL_W] <= head_val;
          board_blank[head_idx]              <= (head_val == '0);
        end else if (drop_cnt != 8'hff) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end

      case (state)
        IDLE:    if (~empty | clear_pend) state <= WAIT_VB;
        WAIT_VB: if (go) state <= clear_pend ? CLEAR : COMMIT;
        CLEAR: begin
`ifdef BOARD_LOCK_EN
          for (int i = 0; i < N_CELLS; i++) begin
            if (!lock_mask[i]) begin
              board[i*CELL_W +: CELL_W] <= '0;
              board_blank[i]            <= 1'b1;
            end
          end
`else
          board       <= '0;
          board_blank <= '1;
`endif
          state <= empty ? IDLE : COMMIT;
        end
        COMMIT: begin
          // A clear raised mid-commit defers the rest of the queue to the next frame.
          if (~vblank | at_limit | clear_pend) begin
            state      <= WAIT_VB;
            hold_frame <= 1'b1;
          end else if (empty) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_board_commit_scheduler.sv
// Bench for board_commit_scheduler: directed scenarios plus a randomized run against a frame-level model.
module tb_board_commit_scheduler;
  import board_commit_scheduler_pkg::*;

  localparam int VA      = 480;
  localparam int MAXC    = 8;
  localparam int DEPTH   = 4;
  localparam int V_FIRST = 420; // active region shortened to keep frames short

  logic         clka = 1'b0;
  logic         rst = 1'b1;
  logic [9:0]   v_cnt = 10'd100;
  logic         req0_valid = 1'b0, req1_valid = 1'b0, clear_req = 1'b0;
  logic [6:0]   req0_idx = '0, req1_idx = '0;
  logic [3:0]   req0_val = '0, req1_val = '0;
  logic         req0_ready, req1_ready, busy, frame_tick;
  logic [323:0] board;
  logic [80:0]  board_blank;
  logic [7:0]   drop_cnt;
  logic [1:0]   dbg_state;
`ifdef BOARD_LOCK_EN
  logic [80:0]  lock_mask = '0;
`endif

  board_commit_scheduler dut (
    .clka        (clka),
    .rst         (rst),
    .v_cnt       (v_cnt),
    .req0_valid  (req0_valid),
    .req0_idx    (req0_idx),
    .req0_val    (req0_val),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_idx    (req1_idx),
    .req1_val    (req1_val),
    .req1_ready  (req1_ready),
    .clear_req   (clear_req),
`ifdef BOARD_LOCK_EN
    .lock_mask   (lock_mask),
`endif
    .board       (board),
    .board_blank (board_blank),
    .busy        (busy),
    .frame_tick  (frame_tick),
    .drop_cnt    (drop_cnt),
    .dbg_state   (dbg_state)
  );

  // clock
  always #5 clka = ~clka;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [323:0] got, input logic [323:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; clear_req = 1'b0; v_cnt = 10'd100;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic push0(input logic [6:0] idx, input logic [3:0] val);
    req0_valid = 1'b1; req0_idx = idx; req0_val = val;
    @(negedge clka); check("push0_ready", req0_ready, 1'b1);
    cyc(); req0_valid = 1'b0;
  endtask

  task automatic push1(input logic [6:0] idx, input logic [3:0] val);
    req1_valid = 1'b1; req1_idx = idx; req1_val = val;
    @(negedge clka); check("push1_ready", req1_ready, 1'b1);
    cyc(); req1_valid = 1'b0;
  endtask

  task automatic blank_for(input int n);
    v_cnt = 10'(VA);
    repeat (n) cyc();
    v_cnt = 10'd100;
    cyc();
  endtask

  // frame-level model: cell contents, queued writes, pending clear, drop count
  int          cells [81];
  int          m_drop;
  bit          m_clear, m_last1, rand_on;
  bit          exp_r0, exp_r1;
  logic [10:0] q [$];
  logic [10:0] ent;
  logic [9:0]  prev_v, prev2_v;

  function automatic logic [323:0] model_board();
    logic [323:0] b = '0;
    for (int i = 0; i < 81; i++) b[i*4 +: 4] = 4'(cells[i]);
    return b;
  endfunction

  function automatic logic [80:0] model_blank();
    logic [80:0] b = '0;
    for (int i = 0; i < 81; i++) b[i] = (cells[i] == 0);
    return b;
  endfunction

  function automatic logic [323:0] seq_board(input int n);
    logic [323:0] b = '0;
    for (int k = 0; k < n; k++) b[(20+k)*4 +: 4] = 4'((k % 9) + 1);
    return b;
  endfunction

  function automatic logic [6:0] rnd_idx();
    if ($urandom_range(0, 9) == 0) return 7'($urandom_range(81, 127));
    return 7'($urandom_range(0, 80));
  endfunction

  // scoreboard: outputs must equal the model throughout active video
  always @(negedge clka) begin
    if (rand_on) begin
      if (v_cnt < 10'(VA)) begin
        check("r_board", board, model_board());
        check("r_blank", board_blank, model_blank());
        check("r_drop", drop_cnt, 8'(m_drop));
        check("r_busy", busy, (q.size() != 0) || m_clear);
      end
      check("r_tick", frame_tick, (prev_v >= 10'(VA)) && (prev2_v < 10'(VA)));
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (q.size() < DEPTH) begin
        if (req0_valid && req1_valid) begin
          if (m_last1) exp_r0 = 1'b1; else exp_r1 = 1'b1;
        end else if (req0_valid) exp_r0 = 1'b1;
        else if (req1_valid) exp_r1 = 1'b1;
      end
      check("r_ready", {req1_ready, req0_ready}, {exp_r1, exp_r0});
      if (exp_r0) begin q.push_back({req0_idx, req0_val}); m_last1 = 1'b0; end
      if (exp_r1) begin q.push_back({req1_idx, req1_val}); m_last1 = 1'b1; end
      if (clear_req) m_clear = 1'b1;
      if (v_cnt >= 10'(VA) && prev_v < 10'(VA)) begin
        if (m_clear) begin
          for (int i = 0; i < 81; i++) cells[i] = 0;
          m_clear = 1'b0;
        end
        for (int n = 0; n < MAXC && q.size() > 0; n++) begin
          ent = q.pop_front();
          if (ent[10:4] <= 7'd80 && ent[3:0] <= 4'd9) cells[ent[10:4]] = int'(ent[3:0]);
          else if (m_drop < 255) m_drop++;
        end
      end
      prev2_v = prev_v;
      prev_v  = v_cnt;
    end
  end

  logic [1:0]   exp_g [5];
  logic [323:0] exp_b;
  logic [80:0]  exp_bl;
  int           k;
  bit           acc;

  initial begin
    // reset state
    do_reset();
    @(negedge clka);
    check("rst_board", board, '0);
    check("rst_blank", board_blank, {81{1'b1}});
    check("rst_busy", busy, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    check("rst_drop", drop_cnt, 8'd0);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_state", dbg_state, 2'(IDLE));

    // single write waits for blanking
    cyc();
    push0(7'd10, 4'd5);
    for (int i = 0; i < 4; i++) begin v_cnt = v_cnt + 10'd1; cyc(); end
    @(negedge clka);
    check("t2_hold", board[43:40], 4'd0);
    check("t2_busy", busy, 1'b1);
    v_cnt = 10'(VA);
    cyc();
    @(negedge clka); check("t2_tick", frame_tick, 1'b1);
    cyc(); cyc();
    @(negedge clka);
    check("t2_cell", board[43:40], 4'd5);
    check("t2_blank10", board_blank[10], 1'b0);
    check("t2_tick_off", frame_tick, 1'b0);

    // round-robin alternation, then full FIFO blocks both
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10; exp_g[4] = 2'b00;
    do_reset();
    req0_valid = 1'b1; req0_idx = 7'd1; req0_val = 4'd1;
    req1_valid = 1'b1; req1_idx = 7'd2; req1_val = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clka);
      check($sformatf("t3_grant%0d", i), {req1_ready, req0_ready}, exp_g[i]);
      cyc();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // ten queued writes: eight land in the first blanking, two in the next
    do_reset();
    k = 0;
    for (int c = 0; c < 60; c++) begin
      v_cnt = (c < 10) ? 10'd100 : (c < 55) ? 10'(VA + c - 10) : 10'd100;
      req0_valid = (k < 10); req0_idx = 7'(20 + k); req0_val = 4'((k % 9) + 1);
      @(negedge clka); acc = req0_valid && req0_ready;
      cyc();
      if (acc) k++;
    end
    req0_valid = 1'b0;
    check("t4_pushed", k, 10);
    check("t4_frame1", board, seq_board(8));
    for (int c = 0; c < 45; c++) begin v_cnt = 10'(VA + c); cyc(); end
    v_cnt = 10'd100; cyc();
    @(negedge clka);
    check("t4_frame2", board, seq_board(10));
    check("t4_busy", busy, 1'b0);

    // clear then commit queued write; out-of-range index is dropped
    do_reset();
    push0(7'd5, 4'd7);
    push1(7'd80, 4'd9);
    blank_for(10);
    exp_b = (324'h9 << 320) | (324'h7 << 20);
    @(negedge clka); check("t5_pre", board, exp_b);
    clear_req = 1'b1; cyc(); clear_req = 1'b0;
    push0(7'd0, 4'd3);
    push1(7'd90, 4'd1);
    blank_for(12);
    exp_b  = 324'h3;
    exp_bl = {{80{1'b1}}, 1'b0};
    @(negedge clka);
    check("t5_board", board, exp_b);
    check("t5_blank", board_blank, exp_bl);
    check("t5_drop", drop_cnt, 8'd1);
    check("t5_busy", busy, 1'b0);

    // reset in the middle of a commit burst
    do_reset();
    push0(7'd3, 4'd4); push0(7'd4, 4'd5); push0(7'd6, 4'd6);
    v_cnt = 10'(VA);
    cyc(); cyc();
    exp_b = 324'h4 << 12;
    @(negedge clka);
    check("t6_state", dbg_state, 2'(COMMIT));
    check("t6_partial", board, exp_b);
    rst = 1'b1;
    cyc();
    @(negedge clka);
    check("t6_board", board, '0);
    check("t6_blank", board_blank, {81{1'b1}});
    check("t6_busy", busy, 1'b0);
    rst = 1'b0;

    // randomized frames against the model
    do_reset();
    v_cnt = 10'(V_FIRST);
    for (int i = 0; i < 81; i++) cells[i] = 0;
    m_drop = 0; m_clear = 1'b0; m_last1 = 1'b1; q.delete();
    prev_v = 10'(V_FIRST); prev2_v = 10'(V_FIRST);
    cyc();
    rand_on = 1'b1;
    for (int f = 0; f < 14; f++) begin
      int rate = $urandom_range(1, 5);
      for (int v = V_FIRST; v < V_TOTAL; v++) begin
        cyc();
        v_cnt     = 10'(v);
        clear_req = (v < VA) && ($urandom_range(0, 49) == 0);
        if (v >= VA) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end else begin
          if (!req0_valid || exp_r0) begin
            req0_valid = ($urandom_range(0, 7) < rate);
            req0_idx   = rnd_idx();
            req0_val   = 4'($urandom_range(0, 11));
          end
          if (!req1_valid || exp_r1) begin
            req1_valid = ($urandom_range(0, 7) < rate);
            req1_idx   = rnd_idx();
            req1_val   = 4'($urandom_range(0, 11));
          end
        end
      end
    end
    cyc();
    v_cnt = 10'(V_FIRST); clear_req = 1'b0;
    repeat (4) cyc();
    rand_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
